// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: holds the decoded slot (PC + instruction),
// captures the live SRAM word into a hold register across stalls, forwards
// operands from prioritized write-back sources and raises a load-use stall.
module id_issue_ctrl #(
  parameter int unsigned NUM_FWD      = 3,
  parameter bit          ZERO_REG_FWD = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     id_stall,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              inst_sram_rdata,
  output logic [4:0]               rf_raddr1,
  output logic [4:0]               rf_raddr2,
  input  logic [31:0]              rf_rdata1,
  input  logic [31:0]              rf_rdata2,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic [5*NUM_FWD-1:0]     fwd_waddr,
  input  logic [32*NUM_FWD-1:0]    fwd_wdata,
  input  logic [NUM_FWD-1:0]       fwd_pending,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [31:0]              src1,
  output logic [31:0]              src2,
  output logic                     stallreq,
  output logic                     issue
);

  typedef enum logic [1:0] {EMPTY, LIVE, HELD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        pend1, pend2;
  logic        any_stall;

  // Lowest-index matching source wins; its pending flag is reported even if a
  // lower-priority source holds ready data, so a stale value is never taken.
  function automatic logic [32:0] resolve(
    input logic [4:0]             addr,
    input logic [31:0]            rf,
    input logic [NUM_FWD-1:0]     we,
    input logic [5*NUM_FWD-1:0]   wa,
    input logic [32*NUM_FWD-1:0]  wd,
    input logic [NUM_FWD-1:0]     pend
  );
    logic        found;
    logic [32:0] r;
    found = 1'b0;
    r     = {1'b0, rf};
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!found && we[i] && (wa[5*i +: 5] == addr)) begin
        found = 1'b1;
        r     = {pend[i], wd[32*i +: 32]};
      end
    end
    if (!ZERO_REG_FWD && (addr == 5'd0)) r = '0;
    return r;
  endfunction

  // Instruction source selection: live SRAM word on the first ID cycle, hold register afterwards.
  always_comb begin
    id_inst = '0;
    case (state_q)
      LIVE:    id_inst = inst_sram_rdata;
      HELD:    id_inst = hold_q;
      default: id_inst = '0;
    endcase
  end

  assign id_valid  = (state_q != EMPTY);
  assign id_pc     = pc_q;
  assign rf_raddr1 = id_inst[25:21];
  assign rf_raddr2 = id_inst[20:16];

  assign {pend1, src1} = resolve(rf_raddr1, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);
  assign {pend2, src2} = resolve(rf_raddr2, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);

  assign stallreq  = id_valid & (pend1 | pend2);
  assign any_stall = id_stall | stallreq;
  assign issue     = id_valid & ~any_stall & ~flush;

  // Next-state logic; flush overrides every stall and clears the hold register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = EMPTY;
      hold_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (if_valid && !id_stall) begin
            state_d = LIVE;
            pc_d    = if_pc;
          end
        end
        LIVE: begin
          if (any_stall) begin
            state_d = HELD;
            hold_d  = inst_sram_rdata;
          end else if (if_valid) begin
            state_d = LIVE;
            pc_d    = if_pc;
          end else begin
            state_d = EMPTY;
          end
        end
        HELD: begin
          if (!any_stall) begin
            if (if_valid) begin
              state_d = LIVE;
              pc_d    = if_pc;
            end else begin
              state_d = EMPTY;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, PC and hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Testbench for id_issue_ctrl: two instances (ZERO_REG_FWD = 0 and 1) share
// stimulus; a slot-level behavioural model is compared on every cycle, plus
// literal expectations for the directed scenarios.
module tb_id_issue_ctrl;

  localparam int unsigned NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, id_stall, if_valid;
  logic [31:0]       if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2;
  logic [NF-1:0]     fwd_we, fwd_pending;
  logic [5*NF-1:0]   fwd_waddr;
  logic [32*NF-1:0]  fwd_wdata;

  logic [4:0]  o_ra1   [2];
  logic [4:0]  o_ra2   [2];
  logic        o_valid [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_inst  [2];
  logic [31:0] o_src1  [2];
  logic [31:0] o_src2  [2];
  logic        o_stall [2];
  logic        o_issue [2];

  id_issue_ctrl #(.NUM_FWD(NF), .ZERO_REG_FWD(1'b0)) u_z0 (
    .clk(clk), .rst(rst), .flush(flush), .id_stall(id_stall), .if_valid(if_valid),
    .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .rf_raddr1(o_ra1[0]), .rf_raddr2(o_ra2[0]), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .id_valid(o_valid[0]), .id_pc(o_pc[0]), .id_inst(o_inst[0]),
    .src1(o_src1[0]), .src2(o_src2[0]), .stallreq(o_stall[0]), .issue(o_issue[0])
  );

  id_issue_ctrl #(.NUM_FWD(NF), .ZERO_REG_FWD(1'b1)) u_z1 (
    .clk(clk), .rst(rst), .flush(flush), .id_stall(id_stall), .if_valid(if_valid),
    .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .rf_raddr1(o_ra1[1]), .rf_raddr2(o_ra2[1]), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .id_valid(o_valid[1]), .id_pc(o_pc[1]), .id_inst(o_inst[1]),
    .src1(o_src1[1]), .src2(o_src2[1]), .stallreq(o_stall[1]), .issue(o_issue[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: a slot is either empty or holds (pc, word); the word is whatever
  // the SRAM bus shows in the slot's first ID cycle and is frozen after that.
  bit          m_valid [2];
  bit          m_first [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_word  [2];
  bit          e_stall [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [zero_reg_fwd=%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic fwd_model(input bit zr, input logic [4:0] a, input logic [31:0] rf,
                           output logic [31:0] d, output bit p);
    d = rf;
    p = 1'b0;
    if (!zr && a == 5'd0) begin
      d = '0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == a) begin
        d = fwd_wdata[32*i +: 32];
        p = fwd_pending[i];
        break;
      end
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; id_stall = 1'b0; if_valid = 1'b0;
    if_pc = '0; inst_sram_rdata = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_pending = '0;
  endtask

  // Compare both instances against the model, away from the clock edge.
  task automatic settle();
    logic [31:0] w, d1, d2;
    bit          p1, p2, ex_issue;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w = m_valid[k] ? (m_first[k] ? inst_sram_rdata : m_word[k]) : 32'h0;
      fwd_model(k == 1, w[25:21], rf_rdata1, d1, p1);
      fwd_model(k == 1, w[20:16], rf_rdata2, d2, p2);
      e_stall[k] = m_valid[k] && (p1 || p2);
      ex_issue   = m_valid[k] && !e_stall[k] && !id_stall && !flush;
      chk("id_valid",  k, 32'(o_valid[k]), 32'(m_valid[k]));
      chk("id_pc",     k, o_pc[k], m_pc[k]);
      chk("id_inst",   k, o_inst[k], w);
      chk("rf_raddr1", k, 32'(o_ra1[k]), 32'(w[25:21]));
      chk("rf_raddr2", k, 32'(o_ra2[k]), 32'(w[20:16]));
      chk("stallreq",  k, 32'(o_stall[k]), 32'(e_stall[k]));
      chk("issue",     k, 32'(o_issue[k]), 32'(ex_issue));
      if (m_valid[k] && !e_stall[k]) begin
        chk("src1", k, o_src1[k], d1);
        chk("src2", k, o_src2[k], d2);
      end
    end
  endtask

  // Advance the model by one clock using the inputs of the current cycle.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0; m_first[k] = 1'b0; m_pc[k] = '0; m_word[k] = '0;
      end else if (flush) begin
        m_valid[k] = 1'b0;
      end else if (!m_valid[k]) begin
        if (if_valid && !id_stall) begin
          m_valid[k] = 1'b1; m_first[k] = 1'b1; m_pc[k] = if_pc;
        end
      end else if (id_stall || e_stall[k]) begin
        if (m_first[k]) m_word[k] = inst_sram_rdata;
        m_first[k] = 1'b0;
      end else if (if_valid) begin
        m_first[k] = 1'b1; m_pc[k] = if_pc;
      end else begin
        m_valid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    set_idle();
    if_valid = 1'b1;
    if_pc    = pc;
    settle();
    advance();
  endtask

  initial begin
    logic [31:0] w;
    set_idle();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_first[k] = 1'b0; m_pc[k] = '0; m_word[k] = '0; e_stall[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_valid[k]), 32'h0);
      chk("rst_pc",    k, o_pc[k], 32'h0);
      chk("rst_inst",  k, o_inst[k], 32'h0);
      chk("rst_stall", k, 32'(o_stall[k]), 32'h0);
      chk("rst_issue", k, 32'(o_issue[k]), 32'h0);
    end
    advance();

    // Single fetch issues one cycle later
    fetch(32'hBFC0_0000);
    inst_sram_rdata = 32'h2408_0005;
    if_valid = 1'b0;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("lit_valid", k, 32'(o_valid[k]), 32'h1);
      chk("lit_pc",    k, o_pc[k], 32'hBFC0_0000);
      chk("lit_inst",  k, o_inst[k], 32'h2408_0005);
      chk("lit_issue", k, 32'(o_issue[k]), 32'h1);
    end
    advance();

    // Three-cycle stall keeps the word while the bus changes
    fetch(32'hBFC0_0004);
    id_stall = 1'b1;
    inst_sram_rdata = 32'h0109_5020;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) inst_sram_rdata = 32'hFFFF_FFFF;
      if (c == 3) id_stall = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) begin
        chk("hold_inst",  k, o_inst[k], 32'h0109_5020);
        chk("hold_issue", k, 32'(o_issue[k]), (c == 3) ? 32'h1 : 32'h0);
      end
      advance();
    end

    // Forwarding priority on rs=8
    fetch(32'hBFC0_0008);
    id_stall = 1'b1;
    inst_sram_rdata = 32'h0109_5020;
    fwd_we = 3'b101;
    fwd_waddr = {5'd8, 5'd1, 5'd8};
    fwd_wdata = {32'h22, 32'h0, 32'h11};
    rf_rdata1 = 32'h33;
    settle();
    for (int k = 0; k < 2; k++) chk("fwd_src0", k, o_src1[k], 32'h11);
    advance();
    inst_sram_rdata = 32'hFFFF_FFFF;
    fwd_we = 3'b100;
    settle();
    for (int k = 0; k < 2; k++) chk("fwd_src2", k, o_src1[k], 32'h22);
    advance();

    // Load-use on rt=9 from source 0, then release
    id_stall = 1'b0;
    fwd_we = 3'b001;
    fwd_waddr = {5'd1, 5'd1, 5'd9};
    fwd_wdata = {32'h0, 32'h0, 32'h44};
    fwd_pending = 3'b001;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("lu_stall", k, 32'(o_stall[k]), 32'h1);
      chk("lu_issue", k, 32'(o_issue[k]), 32'h0);
    end
    advance();
    fwd_pending = 3'b000;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("lu_release", k, 32'(o_stall[k]), 32'h0);
      chk("lu_src2",    k, o_src2[k], 32'h44);
      chk("lu_issue2",  k, 32'(o_issue[k]), 32'h1);
    end
    advance();

    // Flush beats stallreq while HELD
    fetch(32'hBFC0_000C);
    id_stall = 1'b1;
    inst_sram_rdata = 32'h0109_5020;
    settle();
    advance();
    id_stall = 1'b0;
    fwd_we = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd9};
    fwd_pending = 3'b001;
    flush = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) chk("fl_stall_before", k, 32'(o_stall[k]), 32'h1);
    advance();
    flush = 1'b0;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("fl_valid", k, 32'(o_valid[k]), 32'h0);
      chk("fl_inst",  k, o_inst[k], 32'h0);
      chk("fl_stall", k, 32'(o_stall[k]), 32'h0);
    end
    advance();

    // Register 0 forwarding depends on ZERO_REG_FWD
    fetch(32'hBFC0_0010);
    inst_sram_rdata = 32'h0009_5020;
    fwd_we = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd0};
    fwd_wdata = {32'h0, 32'h0, 32'h5};
    rf_rdata1 = 32'h77;
    settle();
    chk("zero_src1", 0, o_src1[0], 32'h0);
    chk("zero_src1", 1, o_src1[1], 32'h5);
    advance();

    // Reset during a stall drops the held slot
    fetch(32'hBFC0_0014);
    id_stall = 1'b1;
    inst_sram_rdata = 32'h0109_5020;
    settle();
    advance();
    rst = 1'b1;
    settle();
    advance();
    set_idle();
    settle();
    for (int k = 0; k < 2; k++) chk("rst_held_valid", k, 32'(o_valid[k]), 32'h0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 8);
      id_stall = ($urandom_range(0, 99) < 30);
      if_valid = ($urandom_range(0, 99) < 70);
      if_pc    = {$urandom} & 32'hFFFF_FFFC;
      w        = $urandom;
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      inst_sram_rdata = w;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      fwd_we    = 3'($urandom);
      for (int i = 0; i < NF; i++) begin
        fwd_waddr[5*i +: 5]  = 5'($urandom_range(0, 3));
        fwd_wdata[32*i +: 32] = $urandom;
        fwd_pending[i]       = ($urandom_range(0, 99) < 20);
      end
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
